lane_hit_judge: RTL and testbench

- Timing-judgement controller for the rhythm game; sits between the per-lane key edge detectors (single-cycle press pulses) and the score/display logic.
- For each lane, opens a hit window when the note scheduler signals a note arrival, grades the player's press as PERFECT, GOOD or MISS, and queues the result.
- A round-robin arbiter serialises pending lane results onto one valid/ready result port and maintains a combo streak counter.

---
 rtl/rhythm_pkg.sv | 23 ++
 rtl/lane_window.sv | 63 ++++++
 rtl/lane_hit_judge.sv | 90 +++++++++
 tb/tb_lane_hit_judge.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/rhythm_pkg.sv
// Shared types and default timing constants for the rhythm-game judge path.
// The note scheduler uses the same window defaults.
package rhythm_pkg;

  typedef enum logic [1:0] {
    G_NONE    = 2'b00,
    G_PERFECT = 2'b01,
    G_GOOD    = 2'b10,
    G_MISS    = 2'b11
  } grade_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPEN = 2'd1,
    PEND = 2'd2
  } lane_state_t;

  localparam int DEF_LANES         = 4;
  localparam int DEF_WIN_W         = 4;
  localparam int DEF_PERFECT_TICKS = 2;
  localparam int DEF_GOOD_TICKS    = 6;

endpackage

// File: rtl/lane_window.sv
// One lane's hit window: opens on note arrival, grades the press (or a timeout
// as MISS), then holds the grade until the arbiter acknowledges it.
module lane_window
  import rhythm_pkg::*;
#(
  parameter int WIN_W         = DEF_WIN_W,
  parameter int PERFECT_TICKS = DEF_PERFECT_TICKS,
  parameter int GOOD_TICKS    = DEF_GOOD_TICKS
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   tick,
  input  logic   note_arrive,
  input  logic   press,
  input  logic   grant_ack,
  output logic   pend,
  output grade_t grade
);

  localparam logic [WIN_W-1:0] PERF_AGE = WIN_W'(PERFECT_TICKS);
  localparam logic [WIN_W-1:0] LAST_AGE = WIN_W'(GOOD_TICKS - 1);

  lane_state_t      r_state;
  logic [WIN_W-1:0] r_age;
  grade_t           r_grade;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_age   <= '0;
      r_grade <= G_NONE;
    end else begin
      case (r_state)
        IDLE: if (note_arrive) begin
          r_state <= OPEN;
          r_age   <= '0;
        end
        // press beats a same-cycle tick and is judged on the current age
        OPEN: if (press) begin
          r_state <= PEND;
          r_grade <= (r_age <= PERF_AGE) ? G_PERFECT : G_GOOD;
        end else if (tick) begin
          if (r_age == LAST_AGE) begin
            r_state <= PEND;
            r_grade <= G_MISS;
          end else begin
            r_age <= r_age + 1'b1;
          end
        end
        PEND: if (grant_ack) begin
          r_grade <= G_NONE;
          r_age   <= '0;
          r_state <= note_arrive ? OPEN : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pend  = (r_state == PEND);
  assign grade = r_grade;

endmodule

// File: rtl/lane_hit_judge.sv
// Per-lane timing judges feeding a locked round-robin arbiter onto a single
// valid/ready result port, plus the saturating combo counter.
module lane_hit_judge
  import rhythm_pkg::*;
#(
  parameter int LANES         = DEF_LANES,
  parameter int WIN_W         = DEF_WIN_W,
  parameter int PERFECT_TICKS = DEF_PERFECT_TICKS,
  parameter int GOOD_TICKS    = DEF_GOOD_TICKS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic [LANES-1:0]         note_arrive,
  input  logic [LANES-1:0]         press,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [$clog2(LANES)-1:0] res_lane,
  output logic [1:0]               res_grade,
  output logic [7:0]               combo
);

  localparam int LW = $clog2(LANES);

  logic [LANES-1:0] w_pend;
  logic [LANES-1:0] w_ack;
  grade_t           w_grade [LANES];
  logic [LW-1:0]    r_ptr, r_lane, w_first, w_grant;
  logic             r_lock;
  logic [7:0]       r_combo;
  logic             w_any, w_hs;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_ack[g] = w_hs && (w_grant == LW'(g));
    lane_window #(
      .WIN_W        (WIN_W),
      .PERFECT_TICKS(PERFECT_TICKS),
      .GOOD_TICKS   (GOOD_TICKS)
    ) u_win (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .note_arrive(note_arrive[g]),
      .press      (press[g]),
      .grant_ack  (w_ack[g]),
      .pend       (w_pend[g]),
      .grade      (w_grade[g])
    );
  end

  // Scan downward so the lowest offset from the pointer wins.
  always_comb begin
    int j;
    j       = 0;
    w_first = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      j = int'(r_ptr) + k;
      if (j >= LANES) j = j - LANES;
      if (w_pend[j]) w_first = LW'(j);
    end
  end

  assign w_any   = |w_pend;
  assign w_hs    = w_any & res_ready;
  assign w_grant = r_lock ? r_lane : w_first;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr   <= '0;
      r_lane  <= '0;
      r_lock  <= 1'b0;
      r_combo <= '0;
    end else if (w_hs) begin
      r_lock <= 1'b0;
      r_ptr  <= (w_grant == LW'(LANES - 1)) ? '0 : w_grant + 1'b1;
      if (w_grade[w_grant] == G_MISS) r_combo <= '0;
      else if (r_combo != 8'hFF)      r_combo <= r_combo + 8'd1;
    end else if (w_any) begin
      // stalled offer: freeze it so later PEND lanes cannot preempt
      r_lock <= 1'b1;
      r_lane <= w_grant;
    end
  end

  assign res_valid = w_any;
  assign res_lane  = w_any ? w_grant : '0;
  assign res_grade = w_any ? w_grade[w_grant] : G_NONE;
  assign combo     = r_combo;

endmodule

// File: tb/tb_lane_hit_judge.sv
// Directed bench for lane_hit_judge: grading, timeout, arbitration order and
// lock, combo saturation, reopen-on-handshake and mid-run reset.
module tb_lane_hit_judge;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic [3:0] note_arrive = '0;
  logic [3:0] press = '0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [1:0] res_lane;
  logic [1:0] res_grade;
  logic [7:0] combo;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lane_hit_judge dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .note_arrive(note_arrive),
    .press      (press),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_lane   (res_lane),
    .res_grade  (res_grade),
    .combo      (combo)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic note(input logic [3:0] m);
    note_arrive = m; cyc(); note_arrive = '0;
  endtask

  task automatic hit(input logic [3:0] m);
    press = m; cyc(); press = '0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; cyc(); tick = 1'b0;
    end
  endtask

  task automatic accept();
    res_ready = 1'b1; cyc(); res_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc(); cyc(); reset = 1'b0;
  endtask

  initial begin
    #1;
    do_reset();
    check("rst_valid", res_valid, 0);
    check("rst_combo", combo, 0);
    check("rst_lane",  res_lane, 0);
    check("rst_grade", res_grade, 0);

    // perfect on lane 0 after one tick
    note(4'b0001); ticks(1); hit(4'b0001);
    check("p0_valid", res_valid, 1);
    check("p0_lane",  res_lane, 0);
    check("p0_grade", res_grade, 1);
    accept();
    check("p0_combo", combo, 1);
    check("p0_clear", res_valid, 0);

    // good on lane 1 after four ticks
    note(4'b0010); ticks(4); hit(4'b0010);
    check("g1_lane",  res_lane, 1);
    check("g1_grade", res_grade, 2);
    accept();
    check("g1_combo", combo, 2);

    // timeout on lane 1: nothing after 5 ticks, MISS after the 6th
    note(4'b0010); ticks(5);
    check("m1_early", res_valid, 0);
    ticks(1);
    check("m1_valid", res_valid, 1);
    check("m1_grade", res_grade, 3);
    accept();
    check("m1_combo", combo, 0);

    // press with tick at age 2 is still perfect
    note(4'b0100); ticks(2);
    press = 4'b0100; tick = 1'b1; cyc(); press = '0; tick = 1'b0;
    check("pt2_lane",  res_lane, 2);
    check("pt2_grade", res_grade, 1);
    accept();
    check("pt2_combo", combo, 1);

    // press on an idle lane is ignored
    hit(4'b1000); ticks(8);
    check("idle_press", res_valid, 0);

    // lane 3 result moves the pointer back to 0 (wrap)
    note(4'b1000); hit(4'b1000);
    check("l3_lane", res_lane, 3);
    accept();
    check("l3_combo", combo, 2);

    // lanes 0,2,3 pending, ready low three cycles
    note(4'b1101); hit(4'b1101);
    for (int i = 0; i < 3; i++) begin
      check("stall_lane", res_lane, 0);
      cyc();
    end
    res_ready = 1'b1;
    check("rr_first", res_lane, 0);
    cyc(); check("rr_second", res_lane, 2);
    cyc(); check("rr_third", res_lane, 3);
    cyc(); res_ready = 1'b0;
    check("rr_drained", res_valid, 0);
    check("rr_combo", combo, 5);

    // pointer back at 0: lanes 0 and 3 pending, lane 0 offered first
    note(4'b1001); hit(4'b1001);
    check("ptr_lane", res_lane, 0);
    accept();
    check("ptr_next", res_lane, 3);
    accept();

    // locked grant on lane 2 is not preempted by lane 0
    note(4'b0101); hit(4'b0100);
    check("lock_first", res_lane, 2);
    hit(4'b0001);
    check("lock_hold", res_lane, 2);
    check("lock_grade", res_grade, 1);
    accept();
    check("lock_after", res_lane, 0);
    accept();
    check("lock_combo", combo, 9);

    // combo saturation
    do_reset();
    for (int i = 0; i < 256; i++) begin
      note(4'b0001); hit(4'b0001); accept();
      if (i == 254) check("sat_255", combo, 255);
    end
    check("sat_hold", combo, 255);

    // note on lane 1 during its own handshake reopens it at age 0
    note(4'b0010); ticks(2); hit(4'b0010);
    res_ready = 1'b1; note_arrive = 4'b0010; cyc();
    res_ready = 1'b0; note_arrive = '0;
    check("reopen_valid", res_valid, 0);
    ticks(2); hit(4'b0010);
    check("reopen_lane",  res_lane, 1);
    check("reopen_grade", res_grade, 1);
    accept();

    // reset with lane 0 OPEN and lane 2 PEND
    note(4'b0101); hit(4'b0100);
    check("pre_rst_valid", res_valid, 1);
    reset = 1'b1; res_ready = 1'b1; cyc(); reset = 1'b0; res_ready = 1'b0;
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_combo", combo, 0);
    hit(4'b0001); ticks(8);
    check("post_rst_none", res_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1);
  end

endmodule
